// File: rtl/clk_div_monitor_if.sv
// Bundles the enable/clear controls, the two monitored clocks and the
// measurement results exchanged between the divider monitor and its users.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             wclk_in;
  logic             rclk_in;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] r_count;
  logic             meas_valid;
  logic             w_ok;
  logic             r_ok;
  logic             locked;
  logic             fault;

  modport master (
    output en, clr, wclk_in, rclk_in,
    input  w_count, r_count, meas_valid, w_ok, r_ok, locked, fault
  );

  modport slave (
    input  en, clr, wclk_in, rclk_in,
    output w_count, r_count, meas_valid, w_ok, r_ok, locked, fault
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: counts wclk/rclk rising edges over a fixed window of
// master-clock cycles, checks each count against the nominal ratio, and
// tracks lock / sticky loss-of-lock status.
module clk_div_monitor #(
  parameter int WINDOW = 12,
  parameter int W_DIV  = 2,
  parameter int R_DIV  = 3,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_monitor_if.slave mon
);

  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int STRK_W = $clog2(LOCK_N + 1);

  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [STRK_W-1:0]       LOCK_MAX = STRK_W'(LOCK_N);
  localparam logic signed [CNT_W:0]   W_EXP    = (CNT_W+1)'(WINDOW / W_DIV);
  localparam logic signed [CNT_W:0]   R_EXP    = (CNT_W+1)'(WINDOW / R_DIV);
  localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Edge counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != {CNT_W{1'b1}}))
      return cnt + 1'b1;
    return cnt;
  endfunction

  // |cnt - expv| <= TOL, evaluated one bit wider so the difference cannot wrap.
  function automatic logic within_tol(input logic [CNT_W-1:0]      cnt,
                                      input logic signed [CNT_W:0] expv);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, cnt}) - expv;
    if (diff < 0)
      diff = -diff;
    return (diff <= TOL_S);
  endfunction

  state_t            state;
  logic [1:0]        arm_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  w_acc;
  logic [CNT_W-1:0]  r_acc;
  logic [STRK_W-1:0] streak;
  logic [2:0]        w_sync;
  logic [2:0]        r_sync;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  r_count;
  logic              meas_valid;
  logic              w_ok;
  logic              r_ok;
  logic              locked;
  logic              fault;

  logic              w_edge;
  logic              r_edge;
  logic [CNT_W-1:0]  w_fin;
  logic [CNT_W-1:0]  r_fin;
  logic              w_fin_ok;
  logic              r_fin_ok;
  logic              win_done;
  logic              fault_set;
  logic [STRK_W-1:0] streak_nxt;

  // Three-flop synchronizers (bit0=s1, bit1=s2, bit2=s3) for both monitored clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_sync <= '0;
      r_sync <= '0;
    end else begin
      w_sync <= {w_sync[1:0], mon.wclk_in};
      r_sync <= {r_sync[1:0], mon.rclk_in};
    end
  end

  // ---- synchronizer / window accumulation boundary ----
  assign w_edge     = w_sync[1] & ~w_sync[2];
  assign r_edge     = r_sync[1] & ~r_sync[2];
  assign w_fin      = sat_inc(w_acc, w_edge);
  assign r_fin      = sat_inc(r_acc, r_edge);
  assign w_fin_ok   = within_tol(w_fin, W_EXP);
  assign r_fin_ok   = within_tol(r_fin, R_EXP);
  assign win_done   = (state == MEASURE) && mon.en && (win_cnt == WIN_LAST);
  assign fault_set  = win_done && !(w_fin_ok && r_fin_ok) && locked;
  assign streak_nxt = (streak == LOCK_MAX) ? streak : streak + 1'b1;

  // Control FSM with window counting, result registers and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arm_cnt    <= '0;
      win_cnt    <= '0;
      w_acc      <= '0;
      r_acc      <= '0;
      streak     <= '0;
      w_count    <= '0;
      r_count    <= '0;
      meas_valid <= 1'b0;
      w_ok       <= 1'b0;
      r_ok       <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // A fault event in the same cycle beats a clear request.
      if (fault_set)
        fault <= 1'b1;
      else if (mon.clr)
        fault <= 1'b0;

      case (state)
        IDLE: begin
          if (mon.en) begin
            state   <= ARM;
            arm_cnt <= '0;
          end
        end
        ARM: begin
          w_acc   <= '0;
          r_acc   <= '0;
          win_cnt <= '0;
          if (!mon.en) begin
            state  <= IDLE;
            locked <= 1'b0;
            streak <= '0;
          end else if (arm_cnt == 2'd2) begin
            state <= MEASURE;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!mon.en) begin
            // Partial window is discarded; published results stay as they are.
            state   <= IDLE;
            locked  <= 1'b0;
            streak  <= '0;
            w_acc   <= '0;
            r_acc   <= '0;
            win_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            w_count    <= w_fin;
            r_count    <= r_fin;
            w_ok       <= w_fin_ok;
            r_ok       <= r_fin_ok;
            meas_valid <= 1'b1;
            w_acc      <= '0;
            r_acc      <= '0;
            win_cnt    <= '0;
            if (w_fin_ok && r_fin_ok) begin
              streak <= streak_nxt;
              locked <= (streak_nxt == LOCK_MAX);
            end else begin
              streak <= '0;
              locked <= 1'b0;
            end
          end else begin
            w_acc   <= w_fin;
            r_acc   <= r_fin;
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- result register boundary ----
  assign mon.w_count    = w_count;
  assign mon.r_count    = r_count;
  assign mon.meas_valid = meas_valid;
  assign mon.w_ok       = w_ok;
  assign mon.r_ok       = r_ok;
  assign mon.locked     = locked;
  assign mon.fault      = fault;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: two instances (TOL=0 and TOL=1) share
// the same stimulus; per-window expectations are queued as each window is
// driven and matched against every meas_valid pulse.
module tb_clk_div_monitor;
  localparam int WINDOW = 12;
  localparam int W_DIV  = 2;
  localparam int R_DIV  = 3;
  localparam int LOCK_N = 4;
  localparam int CNT_W  = 8;
  localparam int W_NOM  = WINDOW / W_DIV;
  localparam int R_NOM  = WINDOW / R_DIV;

  logic clk = 1'b0;
  logic rst;
  logic en, clr, wclk, rclk;

  always #5 clk = ~clk;

  clk_div_monitor_if #(.CNT_W(CNT_W)) if0 ();
  clk_div_monitor_if #(.CNT_W(CNT_W)) if1 ();

  assign if0.en = en;
  assign if0.clr = clr;
  assign if0.wclk_in = wclk;
  assign if0.rclk_in = rclk;
  assign if1.en = en;
  assign if1.clr = clr;
  assign if1.wclk_in = wclk;
  assign if1.rclk_in = rclk;

  clk_div_monitor #(.WINDOW(WINDOW), .W_DIV(W_DIV), .R_DIV(R_DIV), .TOL(0),
                    .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut0 (
    .clk (clk),
    .rst (rst),
    .mon (if0.slave)
  );

  clk_div_monitor #(.WINDOW(WINDOW), .W_DIV(W_DIV), .R_DIV(R_DIV), .TOL(1),
                    .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut1 (
    .clk (clk),
    .rst (rst),
    .mon (if1.slave)
  );

  typedef struct {
    int   w;
    int   r;
    logic wok;
    logic rok;
    logic lk;
    logic ft;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   tol [2] = '{0, 1};
  int   m_streak [2];
  logic m_locked [2];
  logic m_fault [2];

  int   n_chk, n_pass;
  int   cyc, en_edge;
  int   mv_cyc [2];
  int   wdiv, wph, w_sup, rph;
  logic r_on;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_streak[d] = 0;
      m_locked[d] = 1'b0;
      m_fault[d]  = 1'b0;
    end
  endtask

  task automatic model_en_drop();
    for (int d = 0; d < 2; d++) begin
      m_streak[d] = 0;
      m_locked[d] = 1'b0;
    end
  endtask

  // Queue the expected result of the window about to be driven.
  task automatic push_window(input int wexp, input int rexp);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.w   = wexp;
      e.r   = rexp;
      e.wok = (iabs(wexp - W_NOM) <= tol[d]);
      e.rok = (iabs(rexp - R_NOM) <= tol[d]);
      if (e.wok && e.rok) begin
        if (m_streak[d] < LOCK_N) m_streak[d]++;
        m_locked[d] = (m_streak[d] == LOCK_N);
      end else begin
        if (m_locked[d]) m_fault[d] = 1'b1;
        m_streak[d] = 0;
        m_locked[d] = 1'b0;
      end
      e.lk = m_locked[d];
      e.ft = m_fault[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Produce the next sample of both monitored clocks.
  task automatic gen();
    wph  = (wph + 1) % wdiv;
    wclk = (wph == 0);
    if (wclk && w_sup > 0) begin
      wclk = 1'b0;
      w_sup--;
    end
    rph  = (rph + 1) % R_DIV;
    rclk = r_on && (rph == 0);
  endtask

  // Change the wclk ratio while keeping the upcoming sample unchanged.
  task automatic switch_w(input int nd);
    logic nxt_hi;
    nxt_hi = (((wph + 1) % wdiv) == 0);
    wdiv   = nd;
    wph    = nxt_hi ? nd - 1 : 0;
  endtask

  task automatic check_out(input int d, input logic mv,
                           input logic [CNT_W-1:0] wc, input logic [CNT_W-1:0] rc,
                           input logic wok, input logic rok, input logic lk, input logic ft);
    exp_t e;
    int   sz;
    if (mv !== 1'b1) return;
    mv_cyc[d] = cyc;
    sz = (d == 0) ? q0.size() : q1.size();
    chk($sformatf("d%0d_meas_expected", d), (sz > 0), 1);
    if (sz > 0) begin
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("d%0d_w_count@%0d", d, cyc), wc, e.w);
      chk($sformatf("d%0d_r_count@%0d", d, cyc), rc, e.r);
      chk($sformatf("d%0d_w_ok@%0d", d, cyc), wok, e.wok);
      chk($sformatf("d%0d_r_ok@%0d", d, cyc), rok, e.rok);
      chk($sformatf("d%0d_locked@%0d", d, cyc), lk, e.lk);
      chk($sformatf("d%0d_fault@%0d", d, cyc), ft, e.ft);
    end
  endtask

  task automatic tick();
    gen();
    @(posedge clk);
    cyc++;
    #1;
    check_out(0, if0.meas_valid, if0.w_count, if0.r_count, if0.w_ok, if0.r_ok,
              if0.locked, if0.fault);
    check_out(1, if1.meas_valid, if1.w_count, if1.r_count, if1.w_ok, if1.r_ok,
              if1.locked, if1.fault);
  endtask

  task automatic arm();
    en      = 1'b1;
    en_edge = cyc;
    repeat (4) tick();
  endtask

  task automatic run_window(input int sw_at, input int sw_div, input int sup_at, input int sup_n);
    push_window(WINDOW / wdiv - sup_n, r_on ? R_NOM : 0);
    for (int i = 0; i < WINDOW; i++) begin
      if (i == sw_at) switch_w(sw_div);
      if (i == sup_at) w_sup = sup_n;
      tick();
    end
    chk("d0_meas_seen", q0.size(), 0);
    chk("d1_meas_seen", q1.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d0_state"}, dut0.state, 0);
    chk({tag, "_d0_w_count"}, if0.w_count, 0);
    chk({tag, "_d0_r_count"}, if0.r_count, 0);
    chk({tag, "_d0_meas_valid"}, if0.meas_valid, 0);
    chk({tag, "_d0_w_ok"}, if0.w_ok, 0);
    chk({tag, "_d0_r_ok"}, if0.r_ok, 0);
    chk({tag, "_d0_locked"}, if0.locked, 0);
    chk({tag, "_d0_fault"}, if0.fault, 0);
    chk({tag, "_d1_state"}, dut1.state, 0);
    chk({tag, "_d1_w_count"}, if1.w_count, 0);
    chk({tag, "_d1_locked"}, if1.locked, 0);
    chk({tag, "_d1_fault"}, if1.fault, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; en_edge = 0;
    mv_cyc[0] = 0; mv_cyc[1] = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    wdiv = W_DIV; wph = 0; w_sup = 0; rph = 0; r_on = 1'b1;
    wclk = 1'b0; rclk = 1'b0;
    model_reset();

    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // Nominal clocks from cycle 0: pulses at 16, 28, 40, 52, lock on the fourth.
    arm();
    for (int n = 0; n < 4; n++) begin
      run_window(-1, 0, -1, 0);
      chk("t1_meas_cycle", mv_cyc[0], en_edge + 16 + WINDOW * n);
    end
    chk("t1_locked", if0.locked, 1);
    chk("t1_fault", if0.fault, 0);

    // wclk slips to /3 while locked: lock lost and fault raised together.
    run_window(10, 3, -1, 0);
    run_window(-1, 0, -1, 0);
    run_window(-1, 0, -1, 0);
    en = 1'b0;
    model_en_drop();
    tick();
    chk("t3_state_idle", dut0.state, 0);
    chk("t3_fault_held_d0", if0.fault, 1);
    chk("t3_fault_held_d1", if1.fault, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_fault[0] = 1'b0;
    m_fault[1] = 1'b0;
    chk("t3_fault_clr_d0", if0.fault, 0);
    chk("t3_fault_clr_d1", if1.fault, 0);
    wdiv = W_DIV;
    wph  = 0;

    // Lock again, then drop en for one cycle at win_cnt=5.
    arm();
    repeat (4) run_window(-1, 0, -1, 0);
    chk("t4_locked_before", if0.locked, 1);
    repeat (5) tick();
    en = 1'b0;
    tick();
    model_en_drop();
    chk("t4_no_meas", if0.meas_valid, 0);
    chk("t4_state_idle", dut0.state, 0);
    chk("t4_w_count_hold", if0.w_count, W_NOM);
    chk("t4_r_count_hold", if0.r_count, R_NOM);
    chk("t4_w_ok_hold", if0.w_ok, 1);
    chk("t4_locked_clr", if0.locked, 0);
    arm();
    run_window(-1, 0, -1, 0);
    chk("t4_reenable_latency", mv_cyc[0] - en_edge, 16);

    // Tolerance: one missing pulse passes only with TOL=1, two fail both.
    repeat (3) run_window(-1, 0, -1, 0);
    chk("t6_locked_d1", if1.locked, 1);
    run_window(-1, 0, 3, 1);
    chk("t6_d1_still_locked", if1.locked, 1);
    run_window(-1, 0, 3, 2);

    // Reset mid-window with en held high; rclk stays low from here on.
    repeat (6) tick();
    rst  = 1'b1;
    r_on = 1'b0;
    tick();
    model_reset();
    chk_zero("midrst");
    rst = 1'b0;
    arm();
    run_window(-1, 0, -1, 0);
    chk("t5_release_latency", mv_cyc[0] - en_edge, 16);

    // rclk absent: every window fails on r only, never locks.
    repeat (3) run_window(-1, 0, -1, 0);
    chk("t2_locked", if0.locked, 0);
    chk("t2_fault", if0.fault, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Checks the divided clocks (wclk ÷2, rclk ÷3) produced on-chip from the 100 MHz master clock. It counts their rising edges over a fixed window of master-clock cycles, compares each count with the expected value, and reports per-window status. It also reports lock and loss-of-lock status to the FIFO control and test logic.

Parameters:
WINDOW, 12, window length in clk cycles; must be a multiple of lcm(W_DIV, R_DIV)
W_DIV, 2, expected wclk division ratio
R_DIV, 3, expected rclk division ratio
TOL, 0, allowed |count − expected| per window
LOCK_N, 4, consecutive good windows required to assert locked
CNT_W, 8, edge-counter and output width

Ports:
clk  in  1  100 MHz master clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  measurement enable
clr  in  1  clears sticky fault
wclk_in  in  1  monitored ÷2 clock
rclk_in  in  1  monitored ÷3 clock
w_count  out  CNT_W  wclk rising edges counted in last completed window
r_count  out  CNT_W  rclk rising edges counted in last completed window
meas_valid  out  1  one-cycle pulse when counts and status update
w_ok  out  1  last wclk count within tolerance
r_ok  out  1  last rclk count within tolerance
locked  out  1  LOCK_N consecutive good windows seen
fault  out  1  sticky: a bad window occurred while locked

Behaviour:
- Reset: rst=1 at a clk edge forces every output to 0, the state to IDLE, and all counters and synchronizer flops to 0. rst overrides en and clr.
- Input sampling: each monitored clock passes through 3 flops (s1, s2, s3). The edge flag is s2 & ~s3, giving a fixed 2-cycle latency. Because the latency is constant, window counts are unaffected.
- States:
  - IDLE: hold all outputs. If en=1, go to ARM.
  - ARM: 3 cycles to flush the synchronizers, with counters held at 0. Then go to MEASURE. If en=0, go to IDLE.
  - MEASURE: win_cnt runs 0..WINDOW−1.
    - Each edge counter adds its edge flag every cycle and saturates at 2^CNT_W−1.
    - In the cycle where win_cnt=WINDOW−1, that cycle's edge is included.
    - On the following edge: w_count/r_count load the final counts, meas_valid=1 for one cycle, counters and win_cnt restart at 0.
    - Windows run back-to-back with no gap while en stays high.
- Timing: en sampled high in IDLE at edge k gives ARM in cycles k+1..k+3, the first window in k+4..k+15, and meas_valid in cycle k+16. Subsequent pulses follow every WINDOW cycles.
- Tolerance check: w_ok = |count − WINDOW/W_DIV| ≤ TOL, and likewise for r_ok with R_DIV. The check is computed at CNT_W+1 bits to avoid wrap. w_ok/r_ok are registered together with the counts.
- Lock tracking: a window is good when both checks pass.
  - On a good window, streak increments, saturating at LOCK_N.
  - On a bad window, streak resets to 0.
  - locked=1 from the meas_valid cycle in which streak reaches LOCK_N.
  - On a bad window, locked clears in that window's meas_valid cycle. If locked was 1 before that window, fault sets in the same cycle.
- fault: sticky. It clears only on rst, or on clr=1 with no fault-setting event in the same cycle; the set event wins over clr.
- en deasserted during ARM or MEASURE:
  - Go to IDLE next cycle and discard the partial window, with no meas_valid.
  - w_count, r_count, w_ok, r_ok and fault hold.
  - locked and streak clear.
- Re-enable always passes through ARM again.

Test Plan:
1. Drive wclk_in toggling every clk and rclk_in high for 1 of every 3 clks, en=1 from cycle 0, WINDOW=12 → meas_valid at cycles 16, 28, 40, 52 with w_count=6, r_count=4, w_ok=r_ok=1; locked=1 from cycle 52; fault=0.
2. rclk_in held 0, wclk_in nominal → r_count=0, r_ok=0, w_ok=1 on every window; locked and fault stay 0.
3. After lock, switch wclk_in to ÷3 → next full window gives w_count=4, w_ok=0, with locked 1→0 and fault 0→1 in the same meas_valid cycle. fault persists; a one-cycle clr pulse clears it.
4. Drop en for one cycle at win_cnt=5 → no meas_valid, state IDLE, counts hold, locked=0. Re-raise en → next meas_valid exactly 16 cycles later.
5. Assert rst mid-window with en=1 → next cycle all outputs 0 and state IDLE. After release with en=1, the first meas_valid arrives 16 cycles later.
6. TOL=1, suppress one wclk pulse within a window → w_count=5, w_ok=1 and the streak continues. Suppress two pulses → w_count=4, w_ok=0.
